sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
Two-master to one-slave arbiter for the core's sram-like bus. It merges the inst port (master 0) and the data port (master 1) onto a single sram-like port that feeds the AXI bridge. It tracks outstanding transactions in acceptance order, so each slave data_ok and its rdata return to the master that issued the request. It sits between the mips core and the bus bridge, and has zero added latency on both address and data paths.

Parameters:
DEPTH, 4, max outstanding accepted-but-unanswered transactions (power of 2, 2..16)
DATA_PRIO, 1, 1: master 1 (data) wins simultaneous requests; 0: master 0 (inst) wins

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m_req  in  2  per-master request; bit0 inst, bit1 data
m_wr  in  2  per-master write flag
m_size  in  4  per-master size, [1:0] m0, [3:2] m1; 0 byte, 1 half, 2 word
m_addr  in  64  per-master address, [31:0] m0, [63:32] m1
m_wdata  in  64  per-master write data, same packing as m_addr
m_addr_ok  out  2  per-master address accepted
m_data_ok  out  2  per-master response
m_rdata  out  32  read data shared by both masters; valid only with the corresponding m_data_ok bit
s_req  out  1  slave request
s_wr  out  1  slave write
s_size  out  2  slave size
s_addr  out  32  slave address
s_wdata  out  32  slave write data
s_addr_ok  in  1  slave address accepted
s_data_ok  in  1  slave response, in order
s_rdata  in  32  slave read data

Behaviour:
- Protocol:
  - A master holds req and its fields stable until addr_ok.
  - A transfer is accepted in a cycle with req&addr_ok.
  - Exactly one data_ok follows per accepted transfer, in acceptance order. It may arrive in the cycle after acceptance at the earliest.
- Grant (combinational): choose the selected master.
  - If lock=1, the selected master is lock_id.
  - Otherwise it is the priority master among the m_req bits; DATA_PRIO decides simultaneous requests.
- s_req = m_req[sel] & !full & !rst. s_wr, s_size, s_addr and s_wdata are muxed from sel. They are don't-care when s_req=0.
- m_addr_ok[sel] = s_addr_ok & s_req. The other bit is 0.
- Lock register:
  - Set with lock_id<=sel when s_req & !s_addr_ok, so the slave sees a stable request until it accepts.
  - Cleared on s_req & s_addr_ok.
  - A locked master keeps the grant even if the other master has priority.
- Order FIFO: DEPTH entries of 1-bit master id, with rd/wr pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count of log2(DEPTH)+1 bits.
  - Push sel on acceptance (s_req&s_addr_ok).
  - Pop on s_data_ok when count!=0.
  - Push and pop in the same cycle leave count unchanged.
- full = (count==DEPTH). While full, s_req=0 even if a pop occurs the same cycle; this keeps the path free of combinational s_data_ok->s_req.
  - Lock is not affected by full. If lock=1 and full, s_req drops, which is legal only because the slave never acted on the request. The lock is held until acceptance.
- Response routing: m_data_ok[head_id] = s_data_ok & (count!=0); m_rdata = s_rdata, passthrough.
- Stray response: s_data_ok with count==0 is dropped. Neither m_data_ok bit asserts and state is unchanged.
- Reset (synchronous), applied at the next edge:
  - count=0, pointers=0, lock=0, lock_id=0.
  - While rst=1: s_req=0, m_addr_ok=0, m_data_ok=0.
  - Reset mid-operation discards all outstanding entries. Later s_data_ok is treated as stray.
- Latency: address 0 cycles master->slave; response 0 cycles slave->master.
- Throughput: one acceptance per cycle, and one response per cycle concurrently.

Decomposition:
- Shared package: master index constants MST_INST=0 and MST_DATA=1, and size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
- One sub-module, id_fifo: a parameterised 1-bit-wide sync FIFO with push, pop, head, full and count outputs.

Test Plan:
- Single read, inst only: m_req=01 @0x1FC00000 with s_addr_ok=1. Next cycle s_data_ok with s_rdata=0x3C1D0000 -> m_addr_ok=01, then m_data_ok=01 and m_rdata=0x3C1D0000.
- Simultaneous requests, DATA_PRIO=1: m_req=11. Data write @0x80001000, wdata 0xDEADBEEF, size 2 -> s_addr=0x80001000 and s_wr=1, m_addr_ok=10 first, inst accepted the next cycle. Responses route in the order 10, then 01.
- Lock: m_req=01 with s_addr_ok=0 for 3 cycles, and m_req[1] rises in cycle 1 -> s_addr stays the inst address and m_addr_ok[1]=0 until inst is accepted in cycle 3. Data is accepted in cycle 4.
- Full, DEPTH=4: 4 accepted reads with no s_data_ok -> s_req=0 on the 5th request. One s_data_ok -> 5th request accepted the following cycle, and the ids return in order.
- Reset mid-flight: 2 outstanding, pulse rst, then s_data_ok twice -> m_data_ok stays 00 and a new request is accepted normally with count=1.

Source files
------------

// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the two-master sram-like bus arbiter.
// Master ids, size encodings and the lane select helper.
package sram_like_arbiter_pkg;

    localparam logic MST_INST = 1'b0;
    localparam logic MST_DATA = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    function automatic logic [31:0] lane32(input logic [63:0] v, input logic id);
        return id ? v[63:32] : v[31:0];
    endfunction

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order record of which master issued each outstanding transfer.
// One bit per entry; pops on an empty fifo are ignored.
module id_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        din,
    input  logic        pop,
    output logic        head,
    output logic        full,
    output logic [AW:0] count
);

    logic          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges the inst and data sram-like ports onto one slave port,
// returning each response to its issuer with zero added latency.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DATA_PRIO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  m_req,
    input  logic [1:0]  m_wr,
    input  logic [3:0]  m_size,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    output logic [1:0]  m_addr_ok,
    output logic [1:0]  m_data_ok,
    output logic [31:0] m_rdata,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata
);

    localparam int AW = $clog2(DEPTH);

    logic        pri;
    logic        sel;
    logic        lock;
    logic        lock_id;
    logic        full;
    logic        head;
    logic        accept;
    logic        resp;
    logic [AW:0] count;

    always_comb begin
        if (DATA_PRIO != 0) begin
            pri = m_req[MST_DATA] ? MST_DATA : MST_INST;
        end else begin
            pri = m_req[MST_INST] ? MST_INST : MST_DATA;
        end
    end

    // A stalled request keeps the port so the slave sees it unchanged.
    assign sel     = lock ? lock_id : pri;
    assign s_req   = m_req[sel] & ~full & ~rst;
    assign s_wr    = m_wr[sel];
    assign s_size  = sel ? m_size[3:2] : m_size[1:0];
    assign s_addr  = lane32(m_addr, sel);
    assign s_wdata = lane32(m_wdata, sel);

    assign accept  = s_req & s_addr_ok;
    assign resp    = s_data_ok & (count != '0) & ~rst;
    assign m_rdata = s_rdata;

    always_comb begin
        m_addr_ok       = 2'b00;
        m_data_ok       = 2'b00;
        m_addr_ok[sel]  = accept;
        m_data_ok[head] = resp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock    <= 1'b0;
            lock_id <= MST_INST;
        end else if (accept) begin
            lock    <= 1'b0;
        end else if (s_req) begin
            lock    <= 1'b1;
            lock_id <= sel;
        end
    end

    id_fifo #(
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (sel),
        .pop   (s_data_ok),
        .head  (head),
        .full  (full),
        .count (count)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized and directed checks of sram_like_arbiter against a
// transaction-level model: a queue of outstanding ids plus a stall note.
module tb_sram_like_arbiter;

    localparam int DEPTH     = 4;
    localparam int DATA_PRIO = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req;
    logic [1:0]  m_wr;
    logic [3:0]  m_size;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_addr_ok;
    logic [1:0]  m_data_ok;
    logic [31:0] m_rdata;
    logic        s_req;
    logic        s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_addr_ok;
    logic        s_data_ok;
    logic [31:0] s_rdata;

    sram_like_arbiter #(
        .DEPTH     (DEPTH),
        .DATA_PRIO (DATA_PRIO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_size    (m_size),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata),
        .s_req     (s_req),
        .s_wr      (s_wr),
        .s_size    (s_size),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_addr_ok (s_addr_ok),
        .s_data_ok (s_data_ok),
        .s_rdata   (s_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // pending master transfers, held until accepted
    logic        pv  [2];
    logic        pw  [2];
    logic [1:0]  psz [2];
    logic [31:0] pa  [2];
    logic [31:0] pd  [2];

    // model: ids of accepted-but-unanswered transfers, and a stalled master
    logic oq[$];
    logic stall_v;
    logic stall_id;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int i, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        pv[i]  = 1'b1;
        pw[i]  = w;
        psz[i] = sz;
        pa[i]  = a;
        pd[i]  = d;
    endtask

    task automatic run_cycle(input logic aok, input logic dok,
                             input logic [31:0] rd, input logic r);
        logic       g;
        logic       e_sreq;
        logic [1:0] e_aok;
        logic [1:0] e_dok;
        @(negedge clk);
        rst       = r;
        s_addr_ok = aok;
        s_data_ok = dok;
        s_rdata   = rd;
        m_req     = {pv[1], pv[0]};
        m_wr      = {pw[1], pw[0]};
        m_size    = {psz[1], psz[0]};
        m_addr    = {pa[1], pa[0]};
        m_wdata   = {pd[1], pd[0]};
        #1;
        if (stall_v) g = stall_id;
        else if (pv[0] && pv[1]) g = (DATA_PRIO != 0);
        else g = pv[1];
        e_sreq = !r && pv[g] && (oq.size() != DEPTH);
        chk("s_req", 64'(s_req), 64'(e_sreq));
        if (e_sreq) begin
            chk("s_addr", 64'(s_addr), 64'(pa[g]));
            chk("s_wr", 64'(s_wr), 64'(pw[g]));
            chk("s_size", 64'(s_size), 64'(psz[g]));
            chk("s_wdata", 64'(s_wdata), 64'(pd[g]));
        end
        e_aok = (e_sreq && aok) ? (g ? 2'b10 : 2'b01) : 2'b00;
        chk("m_addr_ok", 64'(m_addr_ok), 64'(e_aok));
        e_dok = 2'b00;
        if (!r && dok && oq.size() != 0) e_dok = oq[0] ? 2'b10 : 2'b01;
        chk("m_data_ok", 64'(m_data_ok), 64'(e_dok));
        if (e_dok != 2'b00) chk("m_rdata", 64'(m_rdata), 64'(rd));
        @(posedge clk);
        if (r) begin
            oq.delete();
            stall_v = 1'b0;
        end else begin
            if (e_dok != 2'b00) void'(oq.pop_front());
            if (e_sreq && aok) begin
                oq.push_back(g);
                pv[g]   = 1'b0;
                stall_v = 1'b0;
            end else if (e_sreq) begin
                stall_v  = 1'b1;
                stall_id = g;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            pv[i] = 1'b0; pw[i] = 1'b0; psz[i] = 2'd0; pa[i] = '0; pd[i] = '0;
        end
        stall_v  = 1'b0;
        stall_id = 1'b0;
        rst = 1'b1; s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
        m_req = '0; m_wr = '0; m_size = '0; m_addr = '0; m_wdata = '0;

        run_cycle(1'b1, 1'b1, 32'h0, 1'b1);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // single inst read
        set_m(0, 1'b0, 2'd2, 32'h1FC0_0000, 32'h0);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b0);
        run_cycle(1'b1, 1'b1, 32'h3C1D_0000, 1'b0);

        // simultaneous: data first, then inst; responses in that order
        set_m(0, 1'b0, 2'd2, 32'h1FC0_0004, 32'h0);
        set_m(1, 1'b1, 2'd2, 32'h8000_1000, 32'hDEAD_BEEF);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b0);
        run_cycle(1'b1, 1'b1, 32'h1111_1111, 1'b0);
        run_cycle(1'b0, 1'b1, 32'h2222_2222, 1'b0);

        // lock: inst stalls three cycles while data rises
        set_m(0, 1'b0, 2'd1, 32'h1FC0_0010, 32'h0);
        run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
        set_m(1, 1'b0, 2'd0, 32'h8000_2001, 32'h0);
        run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
        run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b0);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b0);
        run_cycle(1'b0, 1'b1, 32'hAAAA_0000, 1'b0);
        run_cycle(1'b0, 1'b1, 32'hBBBB_0000, 1'b0);

        // full: four reads, fifth held until a response frees a slot
        for (int i = 0; i < 4; i++) begin
            set_m(i % 2, 1'b0, 2'd2, 32'h1000_0000 + 32'(i * 4), 32'h0);
            run_cycle(1'b1, 1'b0, 32'h0, 1'b0);
        end
        set_m(0, 1'b0, 2'd2, 32'h1000_0040, 32'h0);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b0);
        run_cycle(1'b1, 1'b1, 32'h5555_0000, 1'b0);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            run_cycle(1'b0, 1'b1, 32'h6000_0000 + 32'(i), 1'b0);
        end

        // reset mid-flight discards outstanding ids
        set_m(1, 1'b0, 2'd2, 32'h8000_3000, 32'h0);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b0);
        set_m(0, 1'b0, 2'd2, 32'h1FC0_0020, 32'h0);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b0);
        run_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        run_cycle(1'b0, 1'b1, 32'h7777_0000, 1'b0);
        run_cycle(1'b0, 1'b1, 32'h7777_0001, 1'b0);
        set_m(0, 1'b0, 2'd2, 32'h1FC0_0030, 32'h0);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b0);
        run_cycle(1'b0, 1'b1, 32'h8888_0000, 1'b0);
        run_cycle(1'b0, 1'b1, 32'h8888_0001, 1'b0);

        // random traffic, occasional stray responses and resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && $urandom_range(0, 2) != 0) begin
                    set_m(i, (i == 1) ? 1'($urandom_range(0, 1)) : 1'b0,
                          2'($urandom_range(0, 2)), $urandom, $urandom);
                end
            end
            run_cycle(1'($urandom_range(0, 99) < 60),
                      1'($urandom_range(0, 99) < 45),
                      $urandom,
                      1'($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
